// File: rtl/tt_pad_cfg_ctrl.sv
// Runtime pad configuration controller: serial shadow load, checked commit,
// and staged one-pad-per-cycle application onto the pad_cfg bus.
module tt_pad_cfg_ctrl #(
   parameter int unsigned              N_PADS      = 64,
   parameter int unsigned              CFG_W       = 16,
   parameter logic [N_PADS*CFG_W-1:0]  DEFAULT_CFG = '0,
   parameter logic [N_PADS-1:0]        LOCK_MASK   = '0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cfg_sdi,
   input  logic                       cfg_shift,
   input  logic                       cfg_commit,
   input  logic                       cfg_abort,
   output logic                       cfg_sdo,
   output logic [N_PADS*CFG_W-1:0]    pad_cfg,
   output logic                       busy,
   output logic                       done,
   output logic                       err
);

   localparam int unsigned TOTAL = N_PADS * CFG_W;
   localparam int unsigned CNT_W = $clog2(TOTAL + 1);
   localparam int unsigned IDX_W = (N_PADS > 1) ? $clog2(N_PADS) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      APPLY = 2'd2
   } state_t;

   state_t             state;
   logic [TOTAL-1:0]   shadow;
   logic [CNT_W-1:0]   bit_cnt;
   logic               ovf;
   logic [IDX_W-1:0]   pad_idx;

   logic               cnt_full_c;
   logic               idx_last_c;

   assign cnt_full_c = (bit_cnt == CNT_W'(TOTAL));
   assign idx_last_c = (pad_idx == IDX_W'(N_PADS - 1));

   // Controller state, shadow shift register and staged pad application
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         shadow  <= DEFAULT_CFG;
         cfg_sdo <= DEFAULT_CFG[TOTAL-1];
         pad_cfg <= DEFAULT_CFG;
         bit_cnt <= '0;
         ovf     <= 1'b0;
         pad_idx <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               // abort outranks the other strobes even though it does nothing here
               if (cfg_abort) begin
                  state <= IDLE;
               end else if (cfg_commit) begin
                  err <= 1'b1;
               end else if (cfg_shift) begin
                  err     <= 1'b0;
                  ovf     <= 1'b0;
                  shadow  <= {shadow[TOTAL-2:0], cfg_sdi};
                  cfg_sdo <= shadow[TOTAL-2];
                  bit_cnt <= CNT_W'(1);
                  state   <= LOAD;
                  busy    <= 1'b1;
               end
            end

            LOAD: begin
               if (cfg_abort) begin
                  bit_cnt <= '0;
                  ovf     <= 1'b0;
                  state   <= IDLE;
                  busy    <= 1'b0;
               end else if (cfg_commit) begin
                  if (cnt_full_c && !ovf) begin
                     pad_idx <= '0;
                     state   <= APPLY;
                  end else begin
                     err     <= 1'b1;
                     bit_cnt <= '0;
                     state   <= IDLE;
                     busy    <= 1'b0;
                  end
               end else if (cfg_shift) begin
                  shadow  <= {shadow[TOTAL-2:0], cfg_sdi};
                  cfg_sdo <= shadow[TOTAL-2];
                  if (cnt_full_c) begin
                     ovf <= 1'b1;
                  end else begin
                     bit_cnt <= bit_cnt + CNT_W'(1);
                  end
               end
            end

            APPLY: begin
               // locked pads never leave their reset word
               if (!LOCK_MASK[pad_idx]) begin
                  pad_cfg[CFG_W*pad_idx +: CFG_W] <= shadow[CFG_W*pad_idx +: CFG_W];
               end
               if (idx_last_c) begin
                  pad_idx <= '0;
                  bit_cnt <= '0;
                  done    <= 1'b1;
                  state   <= IDLE;
                  busy    <= 1'b0;
               end else begin
                  pad_idx <= pad_idx + IDX_W'(1);
               end
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tt_pad_cfg_ctrl.sv
// Scoreboard bench for tt_pad_cfg_ctrl: stimulus tasks update a transaction
// level model and queue per-cycle expected snapshots; a monitor compares them.
module tb_tt_pad_cfg_ctrl;

   localparam int unsigned N_PADS = 4;
   localparam int unsigned CFG_W  = 4;
   localparam int unsigned TOTAL  = N_PADS * CFG_W;
   localparam logic [TOTAL-1:0]  DEF  = 16'h9E71;
   localparam logic [N_PADS-1:0] LOCK = 4'b1000;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             cfg_sdi = 1'b0;
   logic             cfg_shift = 1'b0;
   logic             cfg_commit = 1'b0;
   logic             cfg_abort = 1'b0;
   logic             cfg_sdo;
   logic [TOTAL-1:0] pad_cfg;
   logic             busy;
   logic             done;
   logic             err;

   tt_pad_cfg_ctrl #(
      .N_PADS      (N_PADS),
      .CFG_W       (CFG_W),
      .DEFAULT_CFG (DEF),
      .LOCK_MASK   (LOCK)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_sdi    (cfg_sdi),
      .cfg_shift  (cfg_shift),
      .cfg_commit (cfg_commit),
      .cfg_abort  (cfg_abort),
      .cfg_sdo    (cfg_sdo),
      .pad_cfg    (pad_cfg),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic             busy;
      logic             done;
      logic             err;
      logic             sdo;
      logic [TOTAL-1:0] pad;
   } snap_t;

   snap_t exp_q[$];
   string tag_q[$];
   int    n_tests = 0;
   int    n_fail  = 0;

   // reference model: the loaded image, bit count and flags as the user sees them
   logic [TOTAL-1:0] m_shadow;
   logic [TOTAL-1:0] m_pad;
   int               m_cnt;
   bit               m_ovf;
   bit               m_err;
   bit               m_loading;

   function automatic snap_t mk(input bit b, input bit d);
      snap_t s;
      s.busy = b;
      s.done = d;
      s.err  = m_err;
      s.sdo  = m_shadow[TOTAL-1];
      s.pad  = m_pad;
      return s;
   endfunction

   task automatic expect_snap(input snap_t s, input string tag);
      exp_q.push_back(s);
      tag_q.push_back(tag);
   endtask

   task automatic model_reset();
      m_shadow  = DEF;
      m_pad     = DEF;
      m_cnt     = 0;
      m_ovf     = 1'b0;
      m_err     = 1'b0;
      m_loading = 1'b0;
   endtask

   // monitor: one expected snapshot per cycle while the scoreboard holds any
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         snap_t e;
         snap_t a;
         string t;
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         a = {busy, done, err, cfg_sdo, pad_cfg};
         n_tests++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got busy=%b done=%b err=%b sdo=%b pad=%h, want busy=%b done=%b err=%b sdo=%b pad=%h",
                     t, a.busy, a.done, a.err, a.sdo, a.pad, e.busy, e.done, e.err, e.sdo, e.pad);
         end
      end
   end

   task automatic do_reset(input string tag);
      rst = 1'b1;
      @(posedge clk);
      model_reset();
      expect_snap(mk(1'b0, 1'b0), tag);
      #1 rst = 1'b0;
   endtask

   // one strobe cycle; an accepted commit also runs the whole apply phase,
   // optionally pulling rst during the cycle that handles pad rst_at
   task automatic step(input bit sh, input bit cm, input bit ab, input bit sd,
                       input int rst_at, input string tag);
      bit accept;
      cfg_shift  = sh;
      cfg_commit = cm;
      cfg_abort  = ab;
      cfg_sdi    = sd;
      @(posedge clk);
      accept = 1'b0;
      if (ab) begin
         if (m_loading) begin
            m_cnt     = 0;
            m_ovf     = 1'b0;
            m_loading = 1'b0;
         end
      end else if (cm) begin
         if (m_loading && m_cnt == int'(TOTAL) && !m_ovf) begin
            accept = 1'b1;
         end else begin
            m_err     = 1'b1;
            m_cnt     = 0;
            m_loading = 1'b0;
         end
      end else if (sh) begin
         if (!m_loading) begin
            m_err     = 1'b0;
            m_ovf     = 1'b0;
            m_cnt     = 1;
            m_loading = 1'b1;
         end else if (m_cnt == int'(TOTAL)) begin
            m_ovf = 1'b1;
         end else begin
            m_cnt++;
         end
         m_shadow = {m_shadow[TOTAL-2:0], sd};
      end
      expect_snap(mk(m_loading || accept, 1'b0), tag);
      #1;
      cfg_shift  = 1'b0;
      cfg_commit = 1'b0;
      cfg_abort  = 1'b0;
      if (accept) begin
         for (int k = 0; k < int'(N_PADS); k++) begin
            // strobes here must all be ignored, shadow stays frozen
            cfg_shift  = 1'($urandom_range(0, 1));
            cfg_commit = 1'($urandom_range(0, 1));
            cfg_abort  = 1'($urandom_range(0, 1));
            cfg_sdi    = 1'($urandom_range(0, 1));
            if (k == rst_at) rst = 1'b1;
            @(posedge clk);
            if (k == rst_at) begin
               model_reset();
               expect_snap(mk(1'b0, 1'b0), {tag, "_rst_in_apply"});
               #1;
               rst        = 1'b0;
               cfg_shift  = 1'b0;
               cfg_commit = 1'b0;
               cfg_abort  = 1'b0;
               return;
            end
            if (!LOCK[k]) m_pad[CFG_W*k +: CFG_W] = m_shadow[CFG_W*k +: CFG_W];
            expect_snap(mk(k < int'(N_PADS) - 1, k == int'(N_PADS) - 1), {tag, "_apply"});
            #1;
            cfg_shift  = 1'b0;
            cfg_commit = 1'b0;
            cfg_abort  = 1'b0;
         end
         m_cnt     = 0;
         m_loading = 1'b0;
      end
   endtask

   // shift the top n bits of v, MSB first; n beyond TOTAL repeats bit 0
   task automatic load(input logic [TOTAL-1:0] v, input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         int b;
         b = (i < int'(TOTAL)) ? int'(TOTAL) - 1 - i : 0;
         step(1'b1, 1'b0, 1'b0, v[b], -1, tag);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      #1;
      do_reset("reset");
      step(1'b0, 1'b0, 1'b0, 1'b0, -1, "idle_after_reset");

      // full load of A5C3, pad 3 locked keeps its default nibble
      load(16'hA5C3, 16, "load_a5c3");
      step(1'b0, 1'b1, 1'b0, 1'b0, -1, "commit_a5c3");
      step(1'b0, 1'b0, 1'b0, 1'b0, -1, "after_done");

      // short load then commit: error, no change; IDLE shift clears it
      load(16'h1234, 15, "load_15");
      step(1'b0, 1'b1, 1'b0, 1'b0, -1, "commit_short");
      step(1'b1, 1'b0, 1'b0, 1'b1, -1, "shift_clears_err");
      step(1'b0, 1'b0, 1'b1, 1'b0, -1, "abort_after_1");

      // overflow load
      load(16'h0F0F, 17, "load_17");
      step(1'b0, 1'b1, 1'b0, 1'b0, -1, "commit_ovf");

      // abort a partial load, then a good one
      load(16'hFFFF, 8, "load_8");
      step(1'b0, 1'b0, 1'b1, 1'b0, -1, "abort_8");
      load(16'h3C6A, 16, "load_3c6a");
      step(1'b0, 1'b1, 1'b0, 1'b0, -1, "commit_3c6a");

      // reset while applying pad 2
      load(16'h7E81, 16, "load_7e81");
      step(1'b0, 1'b1, 1'b0, 1'b0, 2, "commit_rst");

      // commit together with abort: abort wins
      load(16'hBEEF, 16, "load_beef");
      step(1'b0, 1'b1, 1'b1, 1'b0, -1, "commit_abort");
      load(16'hD00D, 16, "load_d00d");
      step(1'b0, 1'b1, 1'b0, 1'b0, -1, "commit_d00d");

      // randomized traffic
      for (int it = 0; it < 150; it++) begin
         int r;
         r = int'($urandom_range(0, 5));
         if (r == 0) begin
            load(16'($urandom), 16, "rnd_load");
            step(1'b0, 1'b1, 1'b0, 1'b0, -1, "rnd_commit");
         end else if (m_loading) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)), -1, "rnd_load_step");
         end else begin
            step(r < 4, r == 4, r == 5, 1'($urandom_range(0, 1)), -1, "rnd_idle_step");
         end
      end

      for (int w = 0; w < 20 && exp_q.size() > 0; w++) @(posedge clk);
      if (exp_q.size() > 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: %0d snapshots left, want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
